trig_lut_arbiter: RTL

//  Shares the single sin/cos lookup table between NREQ requesters (player tanks, bullets).

---
 rtl/trig_lut_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/trig_lut_arbiter.sv
// Round-robin arbiter that shares one sin/cos table between requesters and turns the
// table's Q1.8 magnitudes into signed dx/dy steps. Define TRIG_ARB_FIXED_PRI_EN to give requester 0 fixed priority.
module trig_lut_arbiter #(
    parameter int NREQ    = 4,
    parameter int SPEED_W = 4,
    parameter int LUT_LAT = 0
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*6-1:0]         angle_in,
    input  logic [NREQ*SPEED_W-1:0]   speed_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      ack,
    output logic signed [SPEED_W:0]   dx,
    output logic signed [SPEED_W:0]   dy,
    output logic                      busy,
    output logic [5:0]                lut_angle,
    input  logic [8:0]                lut_sin,
    input  logic [8:0]                lut_cos
);

    localparam int PTR_W  = $clog2(NREQ);
    localparam int CNT_W  = (LUT_LAT > 0) ? $clog2(LUT_LAT + 1) : 1;
    localparam int PROD_W = SPEED_W + 9;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        CALC,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [NREQ-1:0]          gnt_q, gnt_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [5:0]               angle_q, angle_d;
    logic [SPEED_W-1:0]       speed_q, speed_d;
    logic [8:0]               sin_q, sin_d;
    logic [8:0]               cos_q, cos_d;
    logic signed [SPEED_W:0]  dx_q, dx_d;
    logic signed [SPEED_W:0]  dy_q, dy_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [NREQ-1:0]          rr_req;
    logic                     win_found;
    logic                     ptr_adv;
    int                       win_int;
    int                       win_next;
    int                       cand;
    logic [5:0]               sel_angle;
    logic [5:0]               wrap_angle;
    logic [SPEED_W-1:0]       sel_speed;
    logic [PROD_W-1:0]        prod_cos;
    logic [PROD_W-1:0]        prod_sin;
    logic [SPEED_W:0]         mag_cos;
    logic [SPEED_W:0]         mag_sin;
    logic                     cos_neg;
    logic                     sin_neg;

    // Circular search from the pointer; with fixed priority, requester 0 overrides and leaves the pointer alone.
    always_comb begin
        rr_req = req;
`ifdef TRIG_ARB_FIXED_PRI_EN
        rr_req[0] = 1'b0;
`endif
        win_found = 1'b0;
        win_int   = 0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && rr_req[cand]) begin
                win_found = 1'b1;
                win_int   = cand;
            end
        end
        ptr_adv = win_found;
`ifdef TRIG_ARB_FIXED_PRI_EN
        if (req[0]) begin
            win_found = 1'b1;
            win_int   = 0;
            ptr_adv   = 1'b0;
        end
`endif
        win_next = (win_int == NREQ - 1) ? 0 : win_int + 1;
    end

    assign sel_angle  = angle_in[win_int*6 +: 6];
    assign sel_speed  = speed_in[win_int*SPEED_W +: SPEED_W];
    assign wrap_angle = (sel_angle > 6'd44) ? sel_angle - 6'd45 : sel_angle;

    assign prod_cos = PROD_W'(speed_q) * PROD_W'(cos_q);
    assign prod_sin = PROD_W'(speed_q) * PROD_W'(sin_q);
    assign mag_cos  = prod_cos[PROD_W-1:8];
    assign mag_sin  = prod_sin[PROD_W-1:8];

    // Quadrant signs for 8-degree steps: cos < 0 in 96..264 deg, sin < 0 in 184..352 deg.
    assign cos_neg = (angle_q >= 6'd12) && (angle_q <= 6'd33);
    assign sin_neg = (angle_q >= 6'd23) && (angle_q <= 6'd44);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        angle_d = angle_q;
        speed_d = speed_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = LOOKUP;
                    gnt_d   = NREQ'(1) << win_int;
                    angle_d = wrap_angle;
                    speed_d = sel_speed;
                    cnt_d   = '0;
                    if (ptr_adv) ptr_d = PTR_W'(win_next);
                end
            end
            LOOKUP: begin
                if (cnt_q == CNT_W'(LUT_LAT)) begin
                    sin_d   = lut_sin;
                    cos_d   = lut_cos;
                    state_d = CALC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CALC: begin
                dx_d    = cos_neg ? -$signed(mag_cos) : $signed(mag_cos);
                dy_d    = sin_neg ? -$signed(mag_sin) : $signed(mag_sin);
                state_d = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            angle_q <= '0;
            speed_q <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            angle_q <= angle_d;
            speed_q <= speed_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign lut_angle = angle_q;

endmodule
